// File: rtl/crd_drop_unit.sv
// crd_drop_unit: drops outer coordinates whose inner fiber is empty, passes inner stream through; CRD_DROP_STATS_EN adds drop_count
module crd_drop_unit #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        flush,
    input  logic        clk_en,
    input  logic        tile_en,
    input  logic [16:0] outer_crd_in,
    input  logic        outer_crd_in_valid,
    output logic        outer_crd_in_ready,
    input  logic [16:0] inner_crd_in,
    input  logic        inner_crd_in_valid,
    output logic        inner_crd_in_ready,
    output logic [16:0] outer_crd_out,
    output logic        outer_crd_out_valid,
    input  logic        outer_crd_out_ready,
    output logic [16:0] inner_crd_out,
`ifdef CRD_DROP_STATS_EN
    output logic [15:0] drop_count,
`endif
    output logic        inner_crd_out_valid,
    input  logic        inner_crd_out_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [16:0] DONE_TOK = 17'h10100;
    typedef enum logic [2:0] {START, GET_OUTER, SCAN_INNER, FWD_STOP, DONE} state_t;
    state_t state_q, state_d;
    logic [15:0] held_q, held_d;
    logic has_q, has_d, din_q, din_d, dout_q, dout_d;
    logic [16:0] omem_q [FIFO_DEPTH];
    logic [16:0] imem_q [FIFO_DEPTH];
    logic [AW:0] owp_q, orp_q, iwp_q, irp_q;
    logic o_full, i_full, o_pop, i_pop, o_acc, i_acc, o_push, in_stop;
    logic [16:0] o_wdata;
    assign o_full = (owp_q - orp_q) == (AW+1)'(FIFO_DEPTH);
    assign i_full = (iwp_q - irp_q) == (AW+1)'(FIFO_DEPTH);
    assign in_stop = inner_crd_in[16] && inner_crd_in[15:8] == 8'h00;
    assign outer_crd_out_valid = tile_en && owp_q != orp_q;
    assign inner_crd_out_valid = tile_en && iwp_q != irp_q;
    assign outer_crd_out = outer_crd_out_valid ? omem_q[orp_q[AW-1:0]] : '0;
    assign inner_crd_out = inner_crd_out_valid ? imem_q[irp_q[AW-1:0]] : '0;
    assign o_pop = outer_crd_out_valid && outer_crd_out_ready && clk_en;
    assign i_pop = inner_crd_out_valid && inner_crd_out_ready && clk_en;
    assign outer_crd_in_ready = tile_en && !o_full && (state_q == GET_OUTER || state_q == FWD_STOP);
    assign inner_crd_in_ready = tile_en && !i_full &&
        ((state_q == SCAN_INNER && (!in_stop || !has_q || !o_full)) || (state_q == DONE && !din_q));
    assign o_acc = outer_crd_in_valid && outer_crd_in_ready && clk_en;
    assign i_acc = inner_crd_in_valid && inner_crd_in_ready && clk_en;
    // next state and outer FIFO push selection
    always_comb begin
        state_d = state_q;
        held_d = held_q;
        has_d = has_q;
        din_d = din_q;
        dout_d = dout_q;
        o_push = 1'b0;
        o_wdata = outer_crd_in;
        case (state_q)
            START: state_d = tile_en ? GET_OUTER : START;
            GET_OUTER: if (o_acc) begin
                if (!outer_crd_in[16]) begin
                    held_d = outer_crd_in[15:0];
                    has_d = 1'b0;
                    state_d = SCAN_INNER;
                end else if (outer_crd_in == DONE_TOK) begin
                    din_d = 1'b0;
                    dout_d = 1'b0;
                    state_d = DONE;
                end else o_push = 1'b1;
            end
            SCAN_INNER: if (i_acc) begin
                if (!in_stop) has_d = 1'b1;
                else begin
                    o_push = has_q;
                    o_wdata = {1'b0, held_q};
                    state_d = |inner_crd_in[7:0] ? FWD_STOP : GET_OUTER;
                end
            end
            FWD_STOP: if (o_acc) begin
                o_push = 1'b1;
                state_d = GET_OUTER;
            end
            DONE: begin
                din_d = din_q || i_acc;
                if (!dout_q && !o_full && tile_en && clk_en) begin
                    o_push = 1'b1;
                    o_wdata = DONE_TOK;
                    dout_d = 1'b1;
                end
                state_d = (din_d && dout_d) ? START : DONE;
            end
            default: state_d = START;
        endcase
    end
    // state and FIFO pointer registers, frozen while clk_en is low
    always_ff @(posedge clk) begin
        if (flush) begin
            state_q <= START;
            held_q <= '0;
            has_q <= 1'b0;
            din_q <= 1'b0;
            dout_q <= 1'b0;
            owp_q <= '0;
            orp_q <= '0;
            iwp_q <= '0;
            irp_q <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            held_q <= held_d;
            has_q <= has_d;
            din_q <= din_d;
            dout_q <= dout_d;
            owp_q <= owp_q + (AW+1)'(o_push);
            orp_q <= orp_q + (AW+1)'(o_pop);
            iwp_q <= iwp_q + (AW+1)'(i_acc);
            irp_q <= irp_q + (AW+1)'(i_pop);
        end
    end
    // FIFO storage writes
    always_ff @(posedge clk) begin
        if (o_push) omem_q[owp_q[AW-1:0]] <= o_wdata;
        if (i_acc) imem_q[iwp_q[AW-1:0]] <= inner_crd_in;
    end
`ifdef CRD_DROP_STATS_EN
    logic [15:0] drop_q;
    logic drop;
    assign drop = i_acc && state_q == SCAN_INNER && in_stop && !has_q;
    assign drop_count = drop_q;
    // saturating count of dropped outer coordinates
    always_ff @(posedge clk) begin
        if (flush) drop_q <= '0;
        else if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
`endif
endmodule

// File: tb/tb_crd_drop_unit.sv
// tb_crd_drop_unit: scoreboard bench for crd_drop_unit
module tb_crd_drop_unit;
    localparam int DEPTH = 2;
    localparam logic [16:0] D = 17'h10100;
    localparam logic [16:0] S0 = 17'h10000;
    localparam logic [16:0] S1 = 17'h10001;
    logic clk = 1'b0, flush = 1'b1, clk_en = 1'b1, tile_en = 1'b1;
    logic [16:0] outer_crd_in = '0, inner_crd_in = '0, outer_crd_out, inner_crd_out;
    logic outer_crd_in_valid = 1'b0, inner_crd_in_valid = 1'b0;
    logic outer_crd_in_ready, inner_crd_in_ready, outer_crd_out_valid, inner_crd_out_valid;
    logic outer_crd_out_ready = 1'b1, inner_crd_out_ready = 1'b1;
`ifdef CRD_DROP_STATS_EN
    logic [15:0] drop_count;
`endif
    int n_chk = 0, n_fail = 0, exp_drops = 0;
    logic [16:0] oq[$], iq[$], exp_o[$], exp_i[$];

    crd_drop_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .flush(flush), .clk_en(clk_en), .tile_en(tile_en),
        .outer_crd_in(outer_crd_in), .outer_crd_in_valid(outer_crd_in_valid), .outer_crd_in_ready(outer_crd_in_ready),
        .inner_crd_in(inner_crd_in), .inner_crd_in_valid(inner_crd_in_valid), .inner_crd_in_ready(inner_crd_in_ready),
        .outer_crd_out(outer_crd_out), .outer_crd_out_valid(outer_crd_out_valid), .outer_crd_out_ready(outer_crd_out_ready),
        .inner_crd_out(inner_crd_out),
`ifdef CRD_DROP_STATS_EN
        .drop_count(drop_count),
`endif
        .inner_crd_out_valid(inner_crd_out_valid), .inner_crd_out_ready(inner_crd_out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic build();
        int j = 0;
        logic [16:0] u;
        bit hd;
        exp_o.delete();
        exp_i.delete();
        foreach (oq[k]) begin
            if (!oq[k][16]) begin
                hd = 1'b0;
                while (j < iq.size()) begin
                    u = iq[j];
                    j++;
                    if (u[16] && u != D) begin
                        if (hd) exp_o.push_back(oq[k]);
                        else exp_drops++;
                        break;
                    end
                    hd = 1'b1;
                end
            end else exp_o.push_back(oq[k]);
        end
        foreach (iq[k]) exp_i.push_back(iq[k]);
    endtask

    task automatic run(input bit bp, input int stall_at, input bit fl);
        int oi = 0, ii = 0, ipush = 0, ipop = 0;
        logic [17:0] snap_o = '0, snap_i = '0;
        bit prev_en = 1'b1, done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            if (fl && ii >= 1) begin
                flush = 1'b1;
                outer_crd_in_valid = 1'b0;
                inner_crd_in_valid = 1'b0;
                @(posedge clk);
                #1 flush = 1'b0;
                @(negedge clk);
                chk("flush_ovalid", outer_crd_out_valid, 0);
                chk("flush_ivalid", inner_crd_out_valid, 0);
                chk("flush_oready", outer_crd_in_ready, 0);
                chk("flush_iready", inner_crd_in_ready, 0);
`ifdef CRD_DROP_STATS_EN
                chk("flush_drops", drop_count, 0);
`endif
                exp_drops = 0;
                exp_o.delete();
                exp_i.delete();
                @(posedge clk);
                #1;
                return;
            end
            outer_crd_in_valid = oi < oq.size();
            outer_crd_in = outer_crd_in_valid ? oq[oi] : '0;
            inner_crd_in_valid = ii < iq.size();
            inner_crd_in = inner_crd_in_valid ? iq[ii] : '0;
            outer_crd_out_ready = !(bp && c < 10);
            inner_crd_out_ready = !bp || (c % 2 == 0);
            clk_en = !(stall_at >= 0 && c >= stall_at && c < stall_at + 5);
            @(negedge clk);
            if (!clk_en && !prev_en) begin
                chk("frozen_outer", {outer_crd_out_valid, outer_crd_out}, snap_o);
                chk("frozen_inner", {inner_crd_out_valid, inner_crd_out}, snap_i);
            end
            snap_o = {outer_crd_out_valid, outer_crd_out};
            snap_i = {inner_crd_out_valid, inner_crd_out};
            prev_en = clk_en;
            if (bp && ipush - ipop == DEPTH) chk("iready_full", inner_crd_in_ready, 0);
            if (outer_crd_out_valid && outer_crd_out_ready && clk_en) begin
                if (exp_o.size() > 0) chk("outer_out", outer_crd_out, exp_o.pop_front());
                else chk("outer_extra", outer_crd_out_valid, 0);
            end
            if (inner_crd_out_valid && inner_crd_out_ready && clk_en) begin
                ipop++;
                if (exp_i.size() > 0) chk("inner_out", inner_crd_out, exp_i.pop_front());
                else chk("inner_extra", inner_crd_out_valid, 0);
            end
            if (outer_crd_in_valid && outer_crd_in_ready && clk_en) oi++;
            if (inner_crd_in_valid && inner_crd_in_ready && clk_en) begin
                ii++;
                ipush++;
            end
            done = oi == oq.size() && ii == iq.size() && exp_o.size() == 0 && exp_i.size() == 0;
            @(posedge clk);
            #1;
        end
        chk("drained", exp_o.size() + exp_i.size() + (oq.size() - oi) + (iq.size() - ii), 0);
        outer_crd_in_valid = 1'b0;
        inner_crd_in_valid = 1'b0;
        outer_crd_out_ready = 1'b1;
        inner_crd_out_ready = 1'b1;
        clk_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_outer", outer_crd_out_valid, 0);
            chk("idle_inner", inner_crd_out_valid, 0);
        end
`ifdef CRD_DROP_STATS_EN
        chk("drop_count", drop_count, exp_drops);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic mixed();
        oq = '{17'h0, 17'h1, 17'h2, S0, D};
        iq = '{17'h5, S0, S0, 17'h7, S1, D};
        build();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ovalid", outer_crd_out_valid, 0);
        chk("rst_ivalid", inner_crd_out_valid, 0);
        chk("rst_oready", outer_crd_in_ready, 0);
        chk("rst_iready", inner_crd_in_ready, 0);
        chk("rst_odata", outer_crd_out, 0);
        chk("rst_idata", inner_crd_out, 0);
`ifdef CRD_DROP_STATS_EN
        chk("rst_drops", drop_count, 0);
`endif
        @(posedge clk);
        #1 flush = 1'b0;
        mixed();
        run(1'b0, -1, 1'b0);
        oq = '{17'h3, 17'h4, S0, D};
        iq = '{S0, S1, D};
        build();
        run(1'b0, -1, 1'b0);
        mixed();
        run(1'b1, -1, 1'b0);
        mixed();
        run(1'b0, -1, 1'b1);
        mixed();
        run(1'b0, -1, 1'b0);
        repeat (2) begin
            oq = '{D};
            iq = '{D};
            build();
            run(1'b0, -1, 1'b0);
        end
        mixed();
        run(1'b0, 3, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
